// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the front end.
// Holds the default instruction/PC widths, the NOP bubble encoding and the
// (instr, pc) entry type that the fetch queue and later pipeline registers use.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 32;

  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] instr;
    logic [PIPE_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue.
// One synchronous write port and one combinational read port. The storage has
// no reset: the queue's pointers and count decide which entries are meaningful.
//   clk    : clock
//   we     : write enable
//   waddr  : write entry index
//   wdata  : write data
//   raddr  : read entry index
//   rdata  : read data (combinational)
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// IF/ID instruction queue.
// Buffers up to DEPTH fetched (instruction, PC) pairs so fetch can run ahead
// while decode stalls. flush discards everything (including the same-cycle
// push) for branch/jump redirects. When empty, a NOP bubble with PC 0 is
// presented to decode.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset (pointers and count only)
//   in_valid  : fetch presents an instruction
//   in_ready  : queue can accept a push (registered state only)
//   in_instr  : fetched instruction
//   in_pc     : PC of in_instr
//   stall     : decode cannot consume the head
//   flush     : discard queued and incoming instructions
//   out_valid : head entry is valid
//   out_instr : head instruction, NOP_INSTR when empty
//   out_pc    : head PC, 0 when empty
//   count     : number of occupied entries
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = PIPE_DATA_W,
  parameter int                ADDR_W    = PIPE_ADDR_W,
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] NOP_INSTR = PIPE_NOP_INSTR,
  localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] rd_data;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & ~stall & ~flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_instr, in_pc}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Stale storage must never leak to decode, so mask the head when empty.
  assign out_instr = out_valid ? rd_data[ENT_W-1:ADDR_W] : NOP_INSTR;
  assign out_pc    = out_valid ? rd_data[ADDR_W-1:0]     : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of queued entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  always @(posedge clk or negedge rst) begin
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (!rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && !stall;
      do_push = in_valid && (mq.size() != DEPTH);
      e.instr = in_instr;
      e.pc    = in_pc;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", out_valid, mq.size() != 0);
    chk("m_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk("m_pc",    out_pc,    (mq.size() != 0) ? mq[0].pc    : 32'h0);
    chk("m_ready", in_ready,  mq.size() != DEPTH);
    chk("m_count", count,     mq.size());
  end

  // Apply inputs for one edge; returns 2 time units after that edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    in_valid = iv;
    in_instr = ins;
    in_pc    = pc;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] obs [5];
  logic [31:0] exp_drain [5];
  logic [31:0] pcn;
  logic        rdy;

  initial begin
    exp_drain[0] = 32'h0;
    exp_drain[1] = 32'h4;
    exp_drain[2] = 32'h8;
    exp_drain[3] = 32'hC;
    exp_drain[4] = 32'h10;

    // Reset held with fetch active.
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hDEADBEEF;
    in_pc    = 32'h40;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc",    out_pc,    32'h0);
    chk("rst_ready", in_ready,  1);
    chk("rst_count", count,     0);

    rst = 1'b1;
    cycle(1, 32'h20080001, 32'h0, 0, 0);
    chk("first_instr", out_instr, 32'h20080001);
    chk("first_count", count,     1);
    cycle(0, 0, 0, 0, 1);

    // Stall fill.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h1000 + i, 4 * i, 1, 0);
      if (i == 3) begin
        chk("fill_count4", count,    4);
        chk("fill_ready4", in_ready, 0);
      end
    end
    chk("fill_count5", count,  4);
    chk("fill_pc",     out_pc, 32'h0);

    // Drain while pushing.
    pcn = 32'h10;
    for (int k = 0; k < 5; k++) begin
      obs[k] = out_pc;
      rdy = in_ready;
      cycle(1, 32'h2000 + pcn, pcn, 0, 0);
      if (rdy) pcn += 4;
    end
    for (int k = 0; k < 5; k++) chk($sformatf("drain_pc%0d", k), obs[k], exp_drain[k]);
    cycle(0, 0, 0, 0, 1);

    // Flush priority over stall and push.
    for (int i = 0; i < 3; i++) cycle(1, 32'h3000 + i, 32'h80 + 4 * i, 1, 0);
    chk("pre_flush_count", count, 3);
    cycle(1, 32'hDEADDEAD, 32'h100, 1, 1);
    chk("flush_count", count,     0);
    chk("flush_valid", out_valid, 0);
    chk("flush_instr", out_instr, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("flush_gone", out_valid, 0);

    // Simultaneous push/pop at steady occupancy.
    cycle(1, 32'h4200, 32'h200, 1, 0);
    cycle(1, 32'h4204, 32'h204, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp_pc%0d", i), out_pc, 32'h200 + 4 * i);
      cycle(1, 32'h4208 + 4 * i, 32'h208 + 4 * i, 0, 0);
      chk($sformatf("pp_cnt%0d", i), count, 2);
    end
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cycle(1, 32'h5000 + i, 32'h300 + 4 * i, 1, 0);
    chk("pre_ar_count", count, 3);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_instr", out_instr, 32'h0);
    chk("ar_pc",    out_pc,    32'h0);
    chk("ar_ready", in_ready,  1);
    chk("ar_count", count,     0);
    @(posedge clk); #2;
    rst = 1'b1;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("ar_after_valid", out_valid, 0);
    chk("ar_after_count", count,     0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1 rst = 1'b1;
      end
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
